// File: rtl/online_pkg.sv
// online_pkg -- shared definitions for the online multiplier control slice.
//
// Contents:
//   mult_state_t        controller states IDLE, FILL, RUN, FLUSH, DONE
//   SD_POS/SD_NEG/SD_ZERO
//                       signed-digit select encodings driven to the SDVMs
//   clog2()             index width helper (never returns less than 1)

package online_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } mult_state_t;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  // Minimum of one bit so a degenerate single-digit build still has a
  // legal index port.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/sd_digit_sel.sv
// sd_digit_sel -- maps one accepted signed digit {plus,minus} onto the
// digit_select code of an SDVM instance.
//
// Ports:
//   en   in  1  digit is being accepted this cycle
//   dig  in  2  signed digit {plus,minus}
//   sel  out 2  10=+1, 01=-1, 00=0; the code 11 is never produced

module sd_digit_sel
  import online_pkg::*;
(
  input  logic       en,
  input  logic [1:0] dig,
  output logic [1:0] sel
);

  // {1,1} is a redundant encoding of zero, so it collapses onto SD_ZERO
  // together with every cycle that carries no accepted digit.
  always_comb begin
    sel = SD_ZERO;
    if (en) begin
      case (dig)
        SD_POS:  sel = SD_POS;
        SD_NEG:  sel = SD_NEG;
        default: sel = SD_ZERO;
      endcase
    end
  end

endmodule

// File: rtl/online_mult_ctrl.sv
// online_mult_ctrl -- sequencing controller for a digit-serial online
// multiplier built from two SDVM instances and an adder datapath.
//
// Parameters:
//   UNROLLING  digit count per operand (SDVM vector width)
//   DELTA      online delay in cycles before the first product digit
//
// Ports:
//   clk          in   single clock, rising edge
//   asyn_reset   in   synchronous active-high reset
//   abort        in   only with ONLINE_MULT_CTRL_ABORT_EN defined
//   start        in   begins one multiplication when sampled in IDLE
//   in_valid     in   operand digit pair present
//   in_ready     out  controller can accept a digit pair
//   x_dig/y_dig  in   signed digits {plus,minus}
//   x_sel/y_sel  out  digit_select to the SDVMs (10=+1, 01=-1, 00=0)
//   app_we       out  append strobe for the X/Y registers
//   app_idx      out  append position
//   dp_enable    out  datapath enable (low = stall)
//   z_valid      out  product digit valid this cycle
//   busy, done   out  operation in flight / one-cycle completion pulse
//
// Optional feature macro: ONLINE_MULT_CTRL_ABORT_EN adds the abort input.

module online_mult_ctrl
  import online_pkg::*;
#(
  parameter int UNROLLING = 64,
  parameter int DELTA     = 3
) (
  input  logic                          clk,
  input  logic                          asyn_reset,
`ifdef ONLINE_MULT_CTRL_ABORT_EN
  input  logic                          abort,
`endif
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    x_dig,
  input  logic [1:0]                    y_dig,
  output logic [1:0]                    x_sel,
  output logic [1:0]                    y_sel,
  output logic                          app_we,
  output logic [clog2(UNROLLING)-1:0]   app_idx,
  output logic                          dp_enable,
  output logic                          z_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W = clog2(UNROLLING);
  localparam int CNT_W = clog2(UNROLLING + 1);
  localparam int FL_W  = clog2(DELTA + 1);

  localparam logic [CNT_W-1:0] J_LAST  = CNT_W'(UNROLLING);
  localparam logic [CNT_W-1:0] J_FILL  = CNT_W'(DELTA);
  localparam logic [FL_W-1:0]  FL_LAST = FL_W'(DELTA - 1);

  mult_state_t      state;
  mult_state_t      state_next;
  logic [CNT_W-1:0] j;
  logic [CNT_W-1:0] j_next;
  logic [CNT_W-1:0] j_inc;
  logic [FL_W-1:0]  fcnt;
  logic [FL_W-1:0]  fcnt_next;
  logic             z_valid_next;
  logic             abort_req;
  logic             accepting;
  logic             accept;
  logic             flushing;

`ifdef ONLINE_MULT_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // The j != J_LAST term keeps the append index saturated even if the
  // state register were ever to linger in RUN after the last digit.
  assign accepting = ((state == FILL) || (state == RUN)) && (j != J_LAST) && !abort_req;
  assign accept    = accepting && in_valid;
  assign flushing  = (state == FLUSH) && !abort_req;
  assign j_inc     = j + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state   <= IDLE;
      j       <= '0;
      fcnt    <= '0;
      z_valid <= 1'b0;
    end else begin
      state   <= state_next;
      j       <= j_next;
      fcnt    <= fcnt_next;
      z_valid <= z_valid_next;
    end
  end

  // Product digits lag the SDVM select by one cycle, so z_valid is the
  // registered image of "an enabled cycle past the online delay". Those are
  // exactly the RUN accepts and the FLUSH cycles: the first DELTA accepts
  // happen in FILL and produce nothing.
  always_comb begin
    state_next   = state;
    j_next       = j;
    fcnt_next    = fcnt;
    z_valid_next = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = FILL;
          j_next     = '0;
          fcnt_next  = '0;
        end
      end
      FILL: begin
        if (accept) begin
          j_next = j_inc;
          if (j_inc == J_LAST) begin
            state_next = FLUSH;
          end else if (j_inc == J_FILL) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          j_next       = j_inc;
          z_valid_next = 1'b1;
          if (j_inc == J_LAST) begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (flushing) begin
          z_valid_next = 1'b1;
          if (fcnt == FL_LAST) begin
            state_next = DONE;
            fcnt_next  = '0;
          end else begin
            fcnt_next = fcnt + FL_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort drops the operation outright: no flush, no done, no late digit.
    if (abort_req && busy) begin
      state_next   = IDLE;
      j_next       = '0;
      fcnt_next    = '0;
      z_valid_next = 1'b0;
    end
  end

  assign in_ready  = accepting;
  assign app_we    = accept;
  assign app_idx   = accept ? j[IDX_W-1:0] : '0;
  assign dp_enable = accept || flushing;
  assign busy      = (state == FILL) || (state == RUN) || (state == FLUSH);
  assign done      = (state == DONE);

  sd_digit_sel u_x_sel (
    .en  (accept),
    .dig (x_dig),
    .sel (x_sel)
  );

  sd_digit_sel u_y_sel (
    .en  (accept),
    .dig (y_dig),
    .sel (y_sel)
  );

endmodule
